// File: rtl/icetap_jtag_pkg.sv
// Shared TAP state encodings, opcodes and next-state helper for the icetap JTAG TAP.
package icetap_jtag_pkg;

  localparam int unsigned IR_BITS      = 4;
  localparam logic [31:0] IDCODE_VALUE = 32'h1CE7_A001;

  localparam logic [3:0] OPC_EXTEST = 4'h0;
  localparam logic [3:0] OPC_IDCODE = 4'h1;
  localparam logic [3:0] OPC_SCAN_N = 4'h2;
  localparam logic [3:0] OPC_BYPASS = 4'hF;

  typedef enum logic [3:0] {
    TAP_EX2_DR = 4'h0,
    TAP_EX1_DR = 4'h1,
    TAP_SH_DR  = 4'h2,
    TAP_PA_DR  = 4'h3,
    TAP_SEL_IR = 4'h4,
    TAP_UPD_DR = 4'h5,
    TAP_CAP_DR = 4'h6,
    TAP_SEL_DR = 4'h7,
    TAP_EX2_IR = 4'h8,
    TAP_EX1_IR = 4'h9,
    TAP_SH_IR  = 4'hA,
    TAP_PA_IR  = 4'hB,
    TAP_RTI    = 4'hC,
    TAP_UPD_IR = 4'hD,
    TAP_CAP_IR = 4'hE,
    TAP_TLR    = 4'hF
  } tap_state_e;

  // Standard 1149.1 TMS-driven transition function.
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TAP_TLR:    n = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: n = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: n = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  n = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: n = tms ? TAP_UPD_DR : TAP_PA_DR;
      TAP_PA_DR:  n = tms ? TAP_EX2_DR : TAP_PA_DR;
      TAP_EX2_DR: n = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: n = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: n = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  n = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: n = tms ? TAP_UPD_IR : TAP_PA_IR;
      TAP_PA_IR:  n = tms ? TAP_EX2_IR : TAP_PA_IR;
      TAP_EX2_IR: n = tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: n = tms ? TAP_SEL_DR : TAP_RTI;
      default:    n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/icetap_tap_fsm.sv
// 16-state TAP controller; state decodes are registered from the next state so they never glitch.
module icetap_tap_fsm
  import icetap_jtag_pkg::*;
(
  input  logic       tck,
  input  logic       reset,
  input  logic       tms,
  output tap_state_e state,
  output logic       test_logic_reset,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       shift_ir,
  output logic       tdo_oe
);

  tap_state_e state_nxt;

  assign state_nxt = tap_next(state, tms);

  always_ff @(posedge tck) begin
    if (reset) begin
      state            <= TAP_TLR;
      test_logic_reset <= 1'b1;
      capture_dr       <= 1'b0;
      shift_dr         <= 1'b0;
      update_dr        <= 1'b0;
      shift_ir         <= 1'b0;
      tdo_oe           <= 1'b0;
    end else begin
      state            <= state_nxt;
      test_logic_reset <= (state_nxt == TAP_TLR);
      capture_dr       <= (state_nxt == TAP_CAP_DR);
      shift_dr         <= (state_nxt == TAP_SH_DR);
      update_dr        <= (state_nxt == TAP_UPD_DR);
      shift_ir         <= (state_nxt == TAP_SH_IR);
      tdo_oe           <= (state_nxt == TAP_SH_DR) || (state_nxt == TAP_SH_IR);
    end
  end

endmodule

// File: rtl/icetap_jtag_tap.sv
// TAP controller, instruction register, BYPASS/IDCODE data registers and TDO mux for icetap.
module icetap_jtag_tap #(
  parameter int unsigned         IR_BITS      = icetap_jtag_pkg::IR_BITS,
  parameter logic [31:0]         IDCODE_VALUE = icetap_jtag_pkg::IDCODE_VALUE,
  parameter logic [IR_BITS-1:0]  OPC_EXTEST   = IR_BITS'(icetap_jtag_pkg::OPC_EXTEST),
  parameter logic [IR_BITS-1:0]  OPC_IDCODE   = IR_BITS'(icetap_jtag_pkg::OPC_IDCODE),
  parameter logic [IR_BITS-1:0]  OPC_SCAN_N   = IR_BITS'(icetap_jtag_pkg::OPC_SCAN_N),
  parameter logic [IR_BITS-1:0]  OPC_BYPASS   = IR_BITS'(icetap_jtag_pkg::OPC_BYPASS)
) (
  input  logic tck,
  input  logic reset,
  input  logic tms,
  input  logic tdi,
  input  logic icetap_tdo,
  output logic tdo,
  output logic tdo_oe,
  output logic capture_dr,
  output logic shift_dr,
  output logic update_dr,
  output logic scan_n_ir,
  output logic extest_ir,
  output logic test_logic_reset
);

  import icetap_jtag_pkg::*;

  tap_state_e         state;
  logic               shift_ir;
  logic [IR_BITS-1:0] ir;
  logic [IR_BITS-1:0] ir_shift;
  logic               bypass_reg;
  logic [31:0]        idcode_shift;
  logic               sel_idcode;
  logic               sel_bypass;

  icetap_tap_fsm u_fsm (
    .tck              (tck),
    .reset            (reset),
    .tms              (tms),
    .state            (state),
    .test_logic_reset (test_logic_reset),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .shift_ir         (shift_ir),
    .tdo_oe           (tdo_oe)
  );

  // OPC_BYPASS and every undefined opcode fall through to the bypass register.
  assign sel_idcode = (ir == OPC_IDCODE);
  assign sel_bypass = !((ir == OPC_EXTEST) || (ir == OPC_IDCODE) || (ir == OPC_SCAN_N));

  // IR and local DR chains; decoded IR flags are written together with ir.
  always_ff @(posedge tck) begin
    if (reset) begin
      ir           <= OPC_IDCODE;
      ir_shift     <= '0;
      bypass_reg   <= 1'b0;
      idcode_shift <= IDCODE_VALUE;
      scan_n_ir    <= 1'b0;
      extest_ir    <= 1'b0;
    end else begin
      case (state)
        TAP_TLR: begin
          ir        <= OPC_IDCODE;
          scan_n_ir <= (OPC_IDCODE == OPC_SCAN_N);
          extest_ir <= (OPC_IDCODE == OPC_EXTEST);
        end
        TAP_CAP_IR: ir_shift <= IR_BITS'(2'b01);
        TAP_SH_IR:  ir_shift <= {tdi, ir_shift[IR_BITS-1:1]};
        TAP_UPD_IR: begin
          ir        <= ir_shift;
          scan_n_ir <= (ir_shift == OPC_SCAN_N);
          extest_ir <= (ir_shift == OPC_EXTEST);
        end
        TAP_CAP_DR: begin
          if (sel_idcode)      idcode_shift <= IDCODE_VALUE;
          else if (sel_bypass) bypass_reg   <= 1'b0;
        end
        TAP_SH_DR: begin
          if (sel_idcode)      idcode_shift <= {tdi, idcode_shift[31:1]};
          else if (sel_bypass) bypass_reg   <= tdi;
        end
        default: ;
      endcase
    end
  end

  // Pin-level TDO mux; the icetap chains own the DR for SCAN_N and EXTEST.
  always_comb begin
    tdo = 1'b0;
    if (shift_ir) begin
      tdo = ir_shift[0];
    end else if (shift_dr) begin
      if (sel_idcode)      tdo = idcode_shift[0];
      else if (sel_bypass) tdo = bypass_reg;
      else                 tdo = icetap_tdo;
    end
  end

endmodule

// File: tb/tb_icetap_jtag_tap.sv
// Self-checking bench: table-driven TAP model compared every cycle plus directed literal checks.
module tb_icetap_jtag_tap;

  logic tck = 1'b0;
  logic reset = 1'b1, tms = 1'b0, tdi = 1'b0, icetap_tdo = 1'b0;
  logic tdo, tdo_oe, capture_dr, shift_dr, update_dr, scan_n_ir, extest_ir, test_logic_reset;

  icetap_jtag_tap dut (
    .tck(tck), .reset(reset), .tms(tms), .tdi(tdi), .icetap_tdo(icetap_tdo),
    .tdo(tdo), .tdo_oe(tdo_oe), .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .scan_n_ir(scan_n_ir), .extest_ir(extest_ir),
    .test_logic_reset(test_logic_reset)
  );

  always #5 tck = ~tck;

  localparam logic [31:0] IDV = 32'h1CE7_A001;

  // Model state numbering: 0 TLR,1 RTI,2 SEL_DR,3 CAP_DR,4 SH_DR,5 EX1_DR,6 PA_DR,7 EX2_DR,
  // 8 UPD_DR,9 SEL_IR,10 CAP_IR,11 SH_IR,12 EX1_IR,13 PA_IR,14 EX2_IR,15 UPD_IR.
  int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int          m_st, m_ir, m_irs;
  bit          m_byp;
  logic [31:0] m_id;
  bit          m_started = 1'b0;

  int checks = 0;
  int errors = 0;

  logic s_tdo, s_oe, s_cap, s_sh, s_upd, s_scan, s_ext, s_tlr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_bypass_sel(input int ir);
    return !(ir == 0 || ir == 1 || ir == 2);
  endfunction

  task automatic model_step(input bit r, input bit m, input bit d);
    if (r) begin
      m_st = 0; m_ir = 1; m_irs = 0; m_byp = 1'b0; m_id = IDV; m_started = 1'b1;
      return;
    end
    case (m_st)
      0:  m_ir = 1;
      10: m_irs = 1;
      11: m_irs = (m_irs >> 1) + (d ? 8 : 0);
      15: m_ir = m_irs;
      3: begin
        if (m_ir == 1) m_id = IDV;
        else if (m_bypass_sel(m_ir)) m_byp = 1'b0;
      end
      4: begin
        if (m_ir == 1) m_id = (m_id >> 1) | (32'(d) << 31);
        else if (m_bypass_sel(m_ir)) m_byp = d;
      end
      default: ;
    endcase
    m_st = m ? nx1[m_st] : nx0[m_st];
  endtask

  // Compare process: outputs sampled mid-cycle against the model.
  always @(negedge tck) begin
    logic exp_tdo;
    s_tdo = tdo; s_oe = tdo_oe; s_cap = capture_dr; s_sh = shift_dr; s_upd = update_dr;
    s_scan = scan_n_ir; s_ext = extest_ir; s_tlr = test_logic_reset;
    if (m_started) begin
      exp_tdo = 1'b0;
      if (m_st == 11) exp_tdo = m_irs[0];
      else if (m_st == 4) begin
        if (m_ir == 1) exp_tdo = m_id[0];
        else if (m_bypass_sel(m_ir)) exp_tdo = m_byp;
        else exp_tdo = icetap_tdo;
      end
      chk("m_tlr", 32'(test_logic_reset), 32'(m_st == 0));
      chk("m_cap", 32'(capture_dr), 32'(m_st == 3));
      chk("m_sh", 32'(shift_dr), 32'(m_st == 4));
      chk("m_upd", 32'(update_dr), 32'(m_st == 8));
      chk("m_oe", 32'(tdo_oe), 32'(m_st == 4 || m_st == 11));
      chk("m_scan", 32'(scan_n_ir), 32'(m_ir == 2));
      chk("m_ext", 32'(extest_ir), 32'(m_ir == 0));
      chk("m_tdo", 32'(tdo), 32'(exp_tdo));
    end
  end

  task automatic cyc(input bit r, input bit m, input bit d, input bit c);
    reset = r; tms = m; tdi = d; icetap_tdo = c;
    @(posedge tck);
    model_step(r, m, d);
    #1;
  endtask

  task automatic read_idcode(input bit tail);
    logic [31:0] w;
    w = '0;
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 0);
      w[i] = s_tdo;
    end
    chk("idcode_word", w, IDV);
    if (tail) begin
      for (int k = 0; k < 3; k++) begin
        cyc(0, 0, 0, 0);
        chk("idcode_tail_zero", 32'(s_tdo), 32'd0);
      end
    end
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
  endtask

  task automatic load_ir(input logic [3:0] v, output logic [3:0] seen);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, i == 3, v[i], 0);
      seen[i] = s_tdo;
    end
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
  endtask

  bit scan_tms [14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};

  initial begin
    logic [3:0] seen;
    int cc, sc, uc;
    bit c;

    // Reset, then TLR outputs, then RTI.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_tlr", 32'(s_tlr), 32'd1);
    chk("rst_oe", 32'(s_oe), 32'd0);
    chk("rst_dr_flags", 32'({s_cap, s_sh, s_upd}), 32'd0);
    chk("rst_ir_flags", 32'({s_scan, s_ext}), 32'd0);
    chk("rst_tdo", 32'(s_tdo), 32'd0);
    cyc(0, 0, 0, 0);
    chk("rti_tlr", 32'(s_tlr), 32'd0);

    read_idcode(1'b1);

    load_ir(4'h2, seen);
    chk("ir_capture_tdo", 32'(seen), 32'(4'b0001));
    cyc(0, 0, 0, 0);
    chk("scan_n_after_upd", 32'(s_scan), 32'd1);
    chk("extest_after_upd", 32'(s_ext), 32'd0);

    // 8-bit SCAN_N DR scan: flag pulse widths and icetap_tdo pass-through.
    cc = 0; sc = 0; uc = 0;
    for (int i = 0; i < 14; i++) begin
      c = 1'($urandom_range(0, 1));
      cyc(0, scan_tms[i], 1'($urandom_range(0, 1)), c);
      cc += int'(s_cap); sc += int'(s_sh); uc += int'(s_upd);
      if (s_sh) chk("scan_tdo_mirror", 32'(s_tdo), 32'(c));
    end
    chk("capture_cycles", 32'(cc), 32'd1);
    chk("shift_cycles", 32'(sc), 32'd8);
    chk("update_cycles", 32'(uc), 32'd1);

    // Undefined opcode 7 selects bypass: one-cycle delay, captured 0 first.
    load_ir(4'h7, seen);
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0); seen[0] = s_tdo;
    cyc(0, 0, 0, 0); seen[1] = s_tdo;
    cyc(0, 0, 1, 0); seen[2] = s_tdo;
    cyc(0, 1, 1, 0); seen[3] = s_tdo;
    chk("bypass_tdo", 32'(seen), 32'(4'b1010));
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);

    // Five TMS=1 edges from Shift-DR reach TLR, which restores IDCODE.
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("tms5_tlr", 32'(s_tlr), 32'd1);
    read_idcode(1'b0);

    // Reset mid Shift-IR.
    load_ir(4'h2, seen);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    chk("mid_shift_oe", 32'(s_oe), 32'd1);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("midrst_tlr", 32'(s_tlr), 32'd1);
    chk("midrst_oe", 32'(s_oe), 32'd0);
    chk("midrst_scan", 32'(s_scan), 32'd0);

    // Randomised traffic, rare resets.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 99) < 35,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    cyc(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
